// File: rtl/sid_voice_mixer_pkg.sv
// sid_voice_mixer shared types and widths.
// Voice/accumulator/output widths follow the SID register map.
package sid_mix_pkg;

  localparam int VOICE_W     = 12;
  localparam int ACC_W       = 14;
  localparam int SUM_W       = 15;
  localparam int VOL_W       = 4;
  localparam int PROD_W      = 19;
  localparam int OUT_W       = 16;
  localparam int SCALE_SHIFT = 3;

  localparam logic [VOICE_W-1:0] MIDSCALE = 12'h800;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_V1,
    S_ACC_V2,
    S_ACC_V3,
    S_ACC_EXT,
    S_MIX,
    S_SCALE
  } state_e;

  function automatic logic signed [VOICE_W-1:0] to_signed(
    input logic [VOICE_W-1:0] v
  );
    return $signed(v - MIDSCALE);
  endfunction

endpackage

// File: rtl/sid_voice_mixer_if.sv
// Audio source/control bundle between the SID core and the mixer.
// master drives sources and filter return; slave is the mixer.
interface sid_voice_mixer_if;
  import sid_mix_pkg::*;

  logic                     ce_1m;
  logic [VOICE_W-1:0]       voice1;
  logic [VOICE_W-1:0]       voice2;
  logic [VOICE_W-1:0]       voice3;
  logic [VOICE_W-1:0]       ext_in;
  logic [7:0]               res_filt;
  logic [7:0]               mode_vol;
  logic [ACC_W-1:0]         filter_out;
  logic [ACC_W-1:0]         filter_in;
  logic [OUT_W-1:0]         audio_out;
  logic                     sample_valid;
  logic                     overrun;

  modport master (
    output ce_1m, voice1, voice2, voice3,
    output ext_in, res_filt, mode_vol, filter_out,
    input  filter_in, audio_out, sample_valid, overrun
  );

  modport slave (
    input  ce_1m, voice1, voice2, voice3,
    input  ext_in, res_filt, mode_vol, filter_out,
    output filter_in, audio_out, sample_valid, overrun
  );

endinterface

// File: rtl/sid_voice_mixer_vol_scale.sv
// Master volume: 15-bit signed total times 4-bit unsigned volume,
// floor-divided by 8, registered on en_i.
module sid_vol_scale
  import sid_mix_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [SUM_W-1:0] total_i,
  input  logic [VOL_W-1:0]        vol_i,
  output logic [OUT_W-1:0]        audio_o
);

  logic signed [PROD_W-1:0] tot_x;
  logic signed [PROD_W-1:0] vol_x;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]         audio_d;
  logic [OUT_W-1:0]         audio_q;

  always_comb begin
    tot_x   = {{(PROD_W-SUM_W){total_i[SUM_W-1]}}, total_i};
    vol_x   = {{(PROD_W-VOL_W){1'b0}}, vol_i};
    prod    = tot_x * vol_x;
    // |prod| <= 245760, so the shifted value always fits 16 bits
    audio_d = OUT_W'(prod >>> SCALE_SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      audio_q <= '0;
    end else if (en_i) begin
      audio_q <= audio_d;
    end
  end

  assign audio_o = audio_q;

endmodule

// File: rtl/sid_voice_mixer.sv
// SID voice mixer: time-multiplexed filter/direct accumulation,
// filter return recombination and master volume.
module sid_voice_mixer
  import sid_mix_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  sid_voice_mixer_if.slave   bus
);

  state_e state_q, state_d;

  logic signed [VOICE_W-1:0] v1_q, v2_q, v3_q, ext_q;
  logic [3:0]                route_q;
  logic [VOL_W-1:0]          vol_q;
  logic                      mute3_q;

  logic signed [ACC_W-1:0] filt_q, filt_d;
  logic signed [ACC_W-1:0] dir_q, dir_d;
  logic signed [SUM_W-1:0] total_q, total_d;
  logic [ACC_W-1:0]        fin_q, fin_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;
  logic                    snap;
  logic                    scale_en;

  logic signed [VOICE_W-1:0] src;
  logic                      use_filt;
  logic                      add_en;
  logic signed [SUM_W-1:0]   op_a, op_b, sum;
  logic [OUT_W-1:0]          audio;

  logic unused_bits;
  assign unused_bits = ^{bus.res_filt[7:4], bus.mode_vol[6:4]};

  // source select for the single shared adder
  always_comb begin
    src      = '0;
    use_filt = 1'b0;
    add_en   = 1'b0;
    unique case (state_q)
      S_ACC_V1: begin
        src      = v1_q;
        use_filt = route_q[0];
        add_en   = 1'b1;
      end
      S_ACC_V2: begin
        src      = v2_q;
        use_filt = route_q[1];
        add_en   = 1'b1;
      end
      S_ACC_V3: begin
        src      = v3_q;
        use_filt = route_q[2];
        add_en   = route_q[2] | ~mute3_q;
      end
      S_ACC_EXT: begin
        src      = ext_q;
        use_filt = route_q[3];
        add_en   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (state_q == S_MIX) begin
      op_a = {dir_q[ACC_W-1], dir_q};
      op_b = {bus.filter_out[ACC_W-1], bus.filter_out};
    end else begin
      op_a = use_filt ? {filt_q[ACC_W-1], filt_q}
                      : {dir_q[ACC_W-1], dir_q};
      op_b = {{(SUM_W-VOICE_W){src[VOICE_W-1]}}, src};
    end
    sum = op_a + op_b;
  end

  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    dir_d    = dir_q;
    total_d  = total_q;
    fin_d    = fin_q;
    valid_d  = 1'b0;
    ovr_d    = ovr_q;
    snap     = 1'b0;
    scale_en = 1'b0;

    if (bus.ce_1m && state_q != S_IDLE) ovr_d = 1'b1;

    if (add_en) begin
      if (use_filt) filt_d = sum[ACC_W-1:0];
      else          dir_d  = sum[ACC_W-1:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.ce_1m) begin
          snap    = 1'b1;
          filt_d  = '0;
          dir_d   = '0;
          state_d = S_ACC_V1;
        end
      end
      S_ACC_V1:  state_d = S_ACC_V2;
      S_ACC_V2:  state_d = S_ACC_V3;
      S_ACC_V3:  state_d = S_ACC_EXT;
      S_ACC_EXT: state_d = S_MIX;
      S_MIX: begin
        fin_d   = filt_q;
        total_d = sum;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        scale_en = 1'b1;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      filt_q  <= '0;
      dir_q   <= '0;
      total_q <= '0;
      fin_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      dir_q   <= dir_d;
      total_q <= total_d;
      fin_q   <= fin_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // register writes during a sequence only land at the next strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      ext_q   <= '0;
      route_q <= '0;
      vol_q   <= '0;
      mute3_q <= 1'b0;
    end else if (snap) begin
      v1_q    <= to_signed(bus.voice1);
      v2_q    <= to_signed(bus.voice2);
      v3_q    <= to_signed(bus.voice3);
      ext_q   <= $signed(bus.ext_in);
      route_q <= bus.res_filt[3:0];
      vol_q   <= bus.mode_vol[VOL_W-1:0];
      mute3_q <= bus.mode_vol[7];
    end
  end

  sid_vol_scale u_scale (
    .clock   (clock),
    .reset   (reset),
    .en_i    (scale_en),
    .total_i (total_q),
    .vol_i   (vol_q),
    .audio_o (audio)
  );

  assign bus.filter_in    = fin_q;
  assign bus.audio_out    = audio;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Directed vector bench for sid_voice_mixer: routing, mute, volume,
// latency, overrun and reset behaviour.
module tb_sid_voice_mixer;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   vcount;

  sid_voice_mixer_if bus ();

  sid_voice_mixer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.sample_valid === 1'b1) vcount++;
  end

  typedef struct packed {
    logic [11:0] v1;
    logic [11:0] v2;
    logic [11:0] v3;
    logic [11:0] ext;
    logic [7:0]  rf;
    logic [7:0]  mv;
    logic [13:0] fo;
    logic [13:0] fin;
    logic [15:0] aud;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.voice1     = v.v1;
    bus.voice2     = v.v2;
    bus.voice3     = v.v3;
    bus.ext_in     = v.ext;
    bus.res_filt   = v.rf;
    bus.mode_vol   = v.mv;
    bus.filter_out = v.fo;
  endtask

  task automatic pulse_ce();
    bus.ce_1m = 1'b1;
    @(posedge clock);
    #1 bus.ce_1m = 1'b0;
  endtask

  task automatic run(input vec_t v, input int idx, input bit perturb);
    int nv;
    int vat;
    drive(v);
    pulse_ce();
    if (perturb) begin
      bus.voice1   = 12'h000;
      bus.res_filt = 8'h01;
      bus.mode_vol = 8'h00;
    end
    nv  = 0;
    vat = -1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      if (bus.sample_valid === 1'b1) begin
        nv++;
        if (vat < 0) vat = k;
      end
      if (k == 5)
        chk($sformatf("v%0d_fin", idx),
            32'(bus.filter_in), 32'(v.fin));
    end
    chk($sformatf("v%0d_aud", idx),
        32'(bus.audio_out), 32'(v.aud));
    chk($sformatf("v%0d_npulse", idx), nv, 1);
    chk($sformatf("v%0d_lat", idx), vat, 6);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    vcount = 0;

    vecs[0]  = '{12'h800, 12'h800, 12'h800, 12'h000, 8'h00, 8'h0F,
                 14'h0000, 14'h0000, 16'h0000};
    vecs[1]  = '{12'hFFF, 12'h800, 12'h800, 12'h000, 8'h00, 8'h0F,
                 14'h0000, 14'h0000, 16'd3838};
    vecs[2]  = '{12'h000, 12'h800, 12'h800, 12'h000, 8'h01, 8'h08,
                 14'h2000, 14'h3800, 16'hE000};
    vecs[3]  = '{12'h800, 12'h800, 12'hFFF, 12'h000, 8'h00, 8'h8F,
                 14'h0000, 14'h0000, 16'h0000};
    vecs[4]  = '{12'h800, 12'h800, 12'hFFF, 12'h000, 8'h04, 8'h8F,
                 14'h0000, 14'h07FF, 16'h0000};
    vecs[5]  = '{12'hFFF, 12'h800, 12'h800, 12'h000, 8'h00, 8'h8F,
                 14'h0000, 14'h0000, 16'd3838};
    vecs[6]  = '{12'h800, 12'h000, 12'h800, 12'h800, 8'h00, 8'h0F,
                 14'h0000, 14'h0000, 16'hE200};
    vecs[7]  = '{12'h7FF, 12'h800, 12'h800, 12'h000, 8'h00, 8'h01,
                 14'h0000, 14'h0000, 16'hFFFF};
    vecs[8]  = '{12'h000, 12'h800, 12'h800, 12'h000, 8'h01, 8'h00,
                 14'h0100, 14'h3800, 16'h0000};
    vecs[9]  = '{12'hFFF, 12'hFFF, 12'h000, 12'h7FF, 8'h09, 8'h0F,
                 14'h0010, 14'h0FFE, 16'd28};
    vecs[10] = '{12'h000, 12'h000, 12'h000, 12'h800, 8'h00, 8'h0F,
                 14'h2000, 14'h0000, 16'h8800};
    vecs[11] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h7FF, 8'h0F, 8'h0F,
                 14'h1FFF, 14'h1FFC, 16'd15358};

    bus.ce_1m = 1'b0;
    drive(vecs[0]);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_fin", 32'(bus.filter_in), 0);
    chk("rst_aud", 32'(bus.audio_out), 0);
    chk("rst_valid", 32'(bus.sample_valid), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);

    for (int i = 0; i < 12; i++) run(vecs[i], i, 1'b0);

    // mid-sequence register writes must not affect this sample
    run(vecs[1], 100, 1'b1);

    // strobes exactly 7 clocks apart are both accepted
    drive(vecs[1]);
    vcount = 0;
    pulse_ce();
    repeat (6) @(posedge clock);
    #1;
    pulse_ce();
    repeat (20) @(posedge clock);
    #1;
    chk("sp7_pulses", vcount, 2);
    chk("sp7_ovr", 32'(bus.overrun), 0);

    // strobe 3 clocks after acceptance is dropped
    drive(vecs[9]);
    vcount = 0;
    pulse_ce();
    repeat (2) @(posedge clock);
    #1;
    pulse_ce();
    repeat (15) @(posedge clock);
    #1;
    chk("ovr_pulses", vcount, 1);
    chk("ovr_flag", 32'(bus.overrun), 1);
    chk("ovr_aud", 32'(bus.audio_out), 28);
    chk("ovr_fin", 32'(bus.filter_in), 32'h0FFE);

    // reset sampled at e3 aborts the sequence
    drive(vecs[1]);
    vcount = 0;
    pulse_ce();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("mrst_fin", 32'(bus.filter_in), 0);
    chk("mrst_aud", 32'(bus.audio_out), 0);
    chk("mrst_valid", 32'(bus.sample_valid), 0);
    chk("mrst_ovr", 32'(bus.overrun), 0);
    repeat (12) @(posedge clock);
    #1;
    chk("mrst_pulses", vcount, 0);
    chk("mrst_aud2", 32'(bus.audio_out), 0);

    // reset coincident with a strobe drops the strobe
    vcount    = 0;
    reset     = 1'b1;
    bus.ce_1m = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    bus.ce_1m = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("crst_pulses", vcount, 0);
    chk("crst_ovr", 32'(bus.overrun), 0);

    run(vecs[9], 200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
